// File: rtl/ps2_kbd_event_fifo.sv
// PS/2 keyboard event buffer: decodes E0/F0 prefixes into {ext, rel, code} events
// and queues them in a show-ahead FIFO with overflow and error diagnostics.
//
// state    | meaning
// ---------+-------------------------------------------------
// IDLE     | no prefix pending
// GOT_E0   | E0 seen, next plain byte is an extended make
// GOT_F0   | F0 seen, next plain byte is a break
// GOT_E0F0 | both prefixes seen, next plain byte is extended break
module ps2_kbd_event_fifo #(
    parameter int DEPTH         = 16,
    parameter bit DECODE_PREFIX = 1'b1,
    parameter int ERR_CNT_W     = 8
) (
    input  logic                       clk,
    input  logic                       reset_i,
    input  logic [7:0]                 ps2_kbd_code_i,
    input  logic                       ps2_kbd_strobe_i,
    input  logic                       ps2_kbd_err_i,
    output logic                       evt_valid_o,
    output logic [9:0]                 evt_data_o,
    input  logic                       evt_ready_i,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       overflow_o,
    output logic [ERR_CNT_W-1:0]       err_count_o,
    input  logic                       clear_i
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, GOT_E0, GOT_F0, GOT_E0F0} state_t;

    state_t               state_q, state_d;
    logic                 push;
    logic [9:0]           push_data;
    logic                 is_e0, is_f0, bad_byte;
    logic [9:0]           mem [DEPTH];
    logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]        count_q;
    logic [9:0]           head_q, head_d;
    logic                 pop, full, push_ok, drop;
    logic                 ovf_q;
    logic [ERR_CNT_W-1:0] err_cnt_q;

    assign is_e0    = (ps2_kbd_code_i == 8'hE0);
    assign is_f0    = (ps2_kbd_code_i == 8'hF0);
    assign bad_byte = ps2_kbd_strobe_i & ps2_kbd_err_i;

    // Prefix state register.
    always_ff @(posedge clk) begin
        if (reset_i) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Prefix decode: next state and the event to push for each good byte.
    always_comb begin
        state_d   = state_q;
        push      = 1'b0;
        push_data = 10'd0;
        if (bad_byte) begin
            state_d = IDLE;
        end else if (ps2_kbd_strobe_i) begin
            if (!DECODE_PREFIX) begin
                push      = 1'b1;
                push_data = {2'b00, ps2_kbd_code_i};
                state_d   = IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (is_e0)      state_d = GOT_E0;
                        else if (is_f0) state_d = GOT_F0;
                        else begin
                            push      = 1'b1;
                            push_data = {2'b00, ps2_kbd_code_i};
                        end
                    end
                    GOT_E0: begin
                        if (is_e0)      state_d = GOT_E0;
                        else if (is_f0) state_d = GOT_E0F0;
                        else begin
                            push      = 1'b1;
                            push_data = {2'b10, ps2_kbd_code_i};
                            state_d   = IDLE;
                        end
                    end
                    GOT_F0: begin
                        if (is_f0)      state_d = GOT_F0;
                        else if (is_e0) state_d = GOT_E0F0;
                        else begin
                            push      = 1'b1;
                            push_data = {2'b01, ps2_kbd_code_i};
                            state_d   = IDLE;
                        end
                    end
                    GOT_E0F0: begin
                        if (!(is_e0 || is_f0)) begin
                            push      = 1'b1;
                            push_data = {2'b11, ps2_kbd_code_i};
                            state_d   = IDLE;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    assign pop     = (count_q != '0) & evt_ready_i;
    assign full    = (count_q == FULL_CNT);
    assign push_ok = push & (~full | pop);
    assign drop    = push & ~push_ok;

    // Registered head: follows the FIFO head, holds the last event once empty.
    always_comb begin
        head_d = head_q;
        if (pop) begin
            if (count_q == CW'(1)) begin
                if (push_ok) head_d = push_data;
            end else begin
                head_d = mem[rd_ptr_q + AW'(1)];
            end
        end else if ((count_q == '0) && push_ok) begin
            head_d = push_data;
        end
    end

    // FIFO pointers, occupancy and head register.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= 10'd0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
            if (push_ok && !pop)      count_q <= count_q + CW'(1);
            else if (pop && !push_ok) count_q <= count_q - CW'(1);
            head_q <= head_d;
        end
    end

    // Event storage; a full-FIFO push with pop reuses the slot being vacated.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= push_data;
    end

    // Diagnostics: sticky overflow and saturating error count, clear has priority.
    always_ff @(posedge clk) begin
        if (reset_i || clear_i) begin
            ovf_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            if (drop) ovf_q <= 1'b1;
            if (bad_byte && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
        end
    end

    assign evt_valid_o = (count_q != '0);
    assign evt_data_o  = head_q;
    assign count_o     = count_q;
    assign overflow_o  = ovf_q;
    assign err_count_o = err_cnt_q;

endmodule
